blink_rate_ctrl: RTL and testbench

- Upstream control stage for the LED blinker.
- Debounces a raw push-button and steps a 2-bit blink-rate selector on each accepted press (4 rates, wrapping).
- Generates a one-cycle enable tick at the selected rate. The blinker toggles LED on each tick.
- Turns a free-running clk into a user-adjustable blink rate without touching the blinker itself.

---
 rtl/blink_rate_ctrl.sv | 149 ++++++++++++++
 tb/tb_blink_rate_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : blink_rate_ctrl
// Description : Upstream control stage for the LED blinker. Debounces a raw
//               push-button, steps a 2-bit blink-rate selector on every
//               accepted press (wrapping 3 -> 0) and emits a one-cycle enable
//               tick every BASE_DIV<<rate_sel clock cycles.
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               btn       - raw push-button, active-high, may bounce
//               en        - synchronous tick-generator enable
//               tick      - one-cycle enable pulse to the blinker
//               rate_sel  - current rate index, 0 = fastest
//               btn_pulse - one-cycle pulse per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module blink_rate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BASE_DIV        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       en,
  output logic       tick,
  output logic [1:0] rate_sel,
  output logic       btn_pulse
);

  localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int c_PRE_W = $clog2(BASE_DIV * 8);
  // One extra bit so the slowest period (BASE_DIV*8) is representable
  // before the -1 is applied.
  localparam int c_PER_W = c_PRE_W + 1;

  localparam logic [c_DB_W-1:0]  c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PER_W-1:0] c_BASE    = c_PER_W'(BASE_DIV);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  logic               r_sync1;
  logic               r_sync2;
  db_state_t          r_state;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic [c_PRE_W-1:0] r_pre_cnt;
  logic               r_tick;
  logic               r_btn_pulse;
  logic [1:0]         r_rate_sel;

  logic               w_accept;
  logic [c_PER_W-1:0] w_period_last;
  logic               w_terminal;

  // A press is accepted on the edge that leaves PRESS_WAIT towards PRESSED.
  // The prescaler uses the same term so the rate change and counter restart
  // land on one edge.
  assign w_accept      = (r_state == PRESS_WAIT) && r_sync2 && (r_db_cnt == c_DB_LAST);
  assign w_period_last = (c_BASE << r_rate_sel) - c_PER_W'(1);
  assign w_terminal    = ({1'b0, r_pre_cnt} == w_period_last);

  // Two-flop synchronizer; r_sync2 is the only view of the button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with registered press pulse and rate selector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_btn_pulse <= 1'b0;
      r_rate_sel  <= 2'd0;
    end else begin
      r_btn_pulse <= w_accept;
      if (w_accept) begin
        r_rate_sel <= r_rate_sel + 2'd1;
      end
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state  <= PRESS_WAIT;
            r_db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!r_sync2) begin
            r_state <= IDLE;
          end else if (r_db_cnt == c_DB_LAST) begin
            r_state <= PRESSED;
          end else begin
            r_db_cnt <= r_db_cnt + c_DB_W'(1);
          end
        end
        PRESSED: begin
          if (!r_sync2) begin
            r_state  <= RELEASE_WAIT;
            r_db_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high returns to PRESSED without a new pulse.
          if (r_sync2) begin
            r_state <= PRESSED;
          end else if (r_db_cnt == c_DB_LAST) begin
            r_state <= IDLE;
          end else begin
            r_db_cnt <= r_db_cnt + c_DB_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Prescaler. A rate change restarts the period and suppresses any tick
  // that would otherwise have coincided with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (w_accept || !en) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (w_terminal) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
      r_tick    <= 1'b0;
    end
  end

  assign tick      = r_tick;
  assign rate_sel  = r_rate_sel;
  assign btn_pulse = r_btn_pulse;

endmodule
`default_nettype wire

// File: tb/tb_blink_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_rate_ctrl
// Description : Scoreboard bench for blink_rate_ctrl. Stimulus pushes the
//               expected tick / btn_pulse events (cycle and rate_sel) into a
//               queue; a negedge monitor pops and compares whenever the DUT
//               raises either output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_rate_ctrl;

  localparam int DB = 4;
  localparam int BD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       en    = 1'b0;
  logic       tick;
  logic [1:0] rate_sel;
  logic       btn_pulse;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // kind: 1 = tick, 2 = btn_pulse
  typedef struct {
    int         kind;
    int         cyc_at;
    logic [1:0] rate;
  } ev_t;

  ev_t exp_q[$];

  blink_rate_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .BASE_DIV       (BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .en       (en),
    .tick     (tick),
    .rate_sel (rate_sel),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read at negedges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int kind, input int cyc_at, input logic [1:0] rate);
    ev_t ev;
    ev.kind   = kind;
    ev.cyc_at = cyc_at;
    ev.rate   = rate;
    exp_q.push_back(ev);
  endtask

  task automatic push_ticks(input int first, input int period, input int n, input logic [1:0] rate);
    for (int i = 0; i < n; i++) push_ev(1, first + period * i, rate);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    ev_t ev;
    int  kind;
    while (exp_q.size() > 0 && exp_q[0].cyc_at < cyc) begin
      ev = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: kind %0d expected at cycle %0d, not seen (now %0d)",
               ev.kind, ev.cyc_at, cyc);
    end
    if (tick || btn_pulse) begin
      kind = tick ? 1 : 2;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: tick=%0b btn_pulse=%0b rate_sel=%0d at cycle %0d, none expected",
                 tick, btn_pulse, rate_sel, cyc);
      end else begin
        ev = exp_q.pop_front();
        if ((tick && btn_pulse) || kind != ev.kind || ev.cyc_at != cyc || rate_sel != ev.rate) begin
          errors++;
          $display("FAIL event: got kind %0d (tick=%0b pulse=%0b) cycle %0d rate %0d, expected kind %0d cycle %0d rate %0d",
                   kind, tick, btn_pulse, cyc, rate_sel, ev.kind, ev.cyc_at, ev.rate);
        end
      end
    end
  end

  initial begin
    int t0, t1, t2, t3, t4, t5, t6;

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    check_val("reset_tick", int'(tick), 0);
    check_val("reset_rate_sel", int'(rate_sel), 0);
    check_val("reset_btn_pulse", int'(btn_pulse), 0);

    // Rate 0: first tick on the 4th edge after release, then every 4.
    t0 = cyc;
    rst_n = 1'b1;
    en    = 1'b1;
    push_ticks(t0 + 4, 4, 10, 2'd0);
    to_cyc(t0 + 42);
    en = 1'b0;

    // Press while disabled: rate still advances, no ticks for 30 cycles.
    t1 = cyc;
    btn = 1'b1;
    push_ev(2, t1 + 7, 2'd1);
    to_cyc(t1 + 20);
    btn = 1'b0;
    to_cyc(t1 + 30);
    en = 1'b1;
    push_ticks(t1 + 38, 8, 5, 2'd1);

    // Clean press at rate 1 -> rate 2, prescaler restarts at the pulse.
    t2 = t1 + 72;
    to_cyc(t2);
    btn = 1'b1;
    push_ev(1, t2 + 6, 2'd1);
    push_ev(2, t2 + 7, 2'd2);
    push_ticks(t2 + 23, 16, 3, 2'd2);
    to_cyc(t2 + 50);
    btn = 1'b0;

    // Press aligned so the rate change lands on a terminal count (t2+71).
    t3 = t2 + 64;
    to_cyc(t3);
    btn = 1'b1;
    push_ev(2, t3 + 7, 2'd3);
    push_ev(1, t3 + 39, 2'd3);
    to_cyc(t3 + 20);
    btn = 1'b0;
    to_cyc(t3 + 40);
    en = 1'b0;

    // Bounce: 3 high / 1 low x5 never reaches the debounce count.
    t4 = t3 + 45;
    to_cyc(t4);
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
    end
    check_val("bounce_rate_sel", int'(rate_sel), 3);
    btn = 1'b1;
    push_ev(2, t4 + 27, 2'd0);
    to_cyc(t4 + 40);
    btn = 1'b0;

    // Re-enable at rate 0, then a press colliding with the tick at t5+28.
    t5 = t4 + 50;
    to_cyc(t5);
    en = 1'b1;
    push_ticks(t5 + 4, 4, 5, 2'd0);
    to_cyc(t5 + 21);
    btn = 1'b1;
    push_ev(1, t5 + 24, 2'd0);
    push_ev(2, t5 + 28, 2'd1);
    push_ticks(t5 + 36, 8, 2, 2'd1);

    // Asynchronous reset while tick is high and rate_sel is 1.
    to_cyc(t5 + 44);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_reset_tick", int'(tick), 0);
    check_val("async_reset_rate_sel", int'(rate_sel), 0);
    check_val("async_reset_btn_pulse", int'(btn_pulse), 0);
    btn = 1'b0;

    t6 = t5 + 48;
    to_cyc(t6);
    rst_n = 1'b1;
    push_ticks(t6 + 4, 4, 3, 2'd0);
    to_cyc(t6 + 15);
    en = 1'b0;
    to_cyc(t6 + 22);
    check_val("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
